timer_ctrl: RTL and testbench
=============================

Name: timer_ctrl

Overview:
- Upstream control stage for the countdown timer chain (minute/second counter plus hour stage).
- Turns single-cycle button pulses into the level controls start, pause and setting.
- Maintains the BCD preset digits (HH:MM) that the counters load while idle or setting.
- Detects countdown completion and holds a done indication for a fixed time before returning to idle.

Parameters:
- DONE_CYCLES, 10: number of clk cycles the DONE state lasts before auto-return to IDLE; legal range 1..255.

Ports:
- clk  in  1  timer clock; the counters advance one second per clk.
- rst_n  in  1  reset, asynchronous, active-high (despite the name); clock is clk.
- set_p  in  1  one-cycle pulse: enter or leave SET mode.
- sel_p  in  1  one-cycle pulse: advance the selected digit in SET mode.
- inc_p  in  1  one-cycle pulse: increment the selected digit in SET mode.
- start_p  in  1  one-cycle pulse: start, or resume from pause.
- pause_p  in  1  one-cycle pulse: toggle pause while running.
- cnt_zero  in  1  downstream count is 00:00:00 (combinational from the counter stages).
- start  out  1  counter enable level; 0 forces the counters to load the presets.
- pause  out  1  counter freeze level.
- setting  out  1  counters load presets continuously.
- set_min_one  out  4  BCD preset, 0..9.
- set_min_ten  out  4  BCD preset, 0..5.
- set_hr_one  out  4  BCD preset, 0..9, or 0..3 when set_hr_ten==2.
- set_hr_ten  out  4  BCD preset, 0..2.
- sel_digit  out  2  0=min_one, 1=min_ten, 2=hr_one, 3=hr_ten.
- done  out  1  high throughout the DONE state.

Behaviour:
- States: IDLE, SET, RUN, PAUSE, DONE. All outputs are registered.
- Reset (asynchronous, any time, including mid-RUN) forces:
  - state IDLE;
  - all preset digits 0, sel_digit 0;
  - start=0, pause=0, setting=0, done=0;
  - done counter 0.
- Output decode per state:
  - IDLE: start=0, pause=0, setting=0.
  - SET: start=0, setting=1.
  - RUN: start=1, pause=0.
  - PAUSE: start=1, pause=1.
  - DONE: start=1, pause=1, done=1.
- Outputs change on the clk edge at which the state changes.
- Transitions (evaluated at posedge clk). Pulse priority within one cycle: set_p > start_p > pause_p; lower-priority pulses that cycle are ignored.
  - IDLE --set_p--> SET. On entry, sel_digit is set to 0.
  - IDLE --start_p--> RUN, only if the presets are not all zero. With all-zero presets, start_p is ignored and the block stays in IDLE.
  - SET --set_p--> IDLE.
  - In SET, start_p and pause_p are ignored.
  - RUN --pause_p--> PAUSE.
  - RUN --set_p--> IDLE (abort; counters reload the presets).
  - RUN --cnt_zero, sampled in RUN after at least one cycle in RUN--> DONE. This rule is lower priority than set_p.
  - PAUSE --pause_p or start_p--> RUN.
  - PAUSE --set_p--> IDLE.
  - In PAUSE, cnt_zero is ignored.
  - DONE: the done counter increments each cycle. At DONE_CYCLES-1 the next state is IDLE and the counter clears.
  - DONE --set_p or start_p--> IDLE immediately; the counter clears.
- Digit editing (SET only):
  - sel_p: sel_digit increments 0→1→2→3→0.
  - inc_p increments only the selected digit:
    - min_one: 9→0.
    - min_ten: 5→0.
    - hr_one: 9→0 when hr_ten<2; 3→0 when hr_ten==2.
    - hr_ten: 2→0. When stepping 1→2 with hr_one>3, hr_one clamps to 3 in the same cycle.
  - sel_p and inc_p in the same cycle: the increment applies to the current digit, and the select advances for the next cycle.
  - inc_p and sel_p outside SET are ignored; presets hold.
- Presets are never modified by the countdown. On return to IDLE the counters reload the same values.
- No state is reachable except via the transitions above. Unused encodings recover to IDLE on the next clk.

Test Plan:
- Reset mid-RUN: preset 00:01, start_p, run 5 cycles, assert rst_n → same-cycle start=0, setting=0, done=0, all presets 0, state IDLE.
- Editing and wrap:
  - set_p, then 10×inc_p → set_min_one=0.
  - sel_p, 6×inc_p → set_min_ten=0.
  - 2×sel_p to hr_ten, then inc_p 2×, with hr_one previously set to 7 → hr_ten=2, hr_one=3.
  - set_p → IDLE, setting=0.
- Zero preset guard: all presets 0, start_p → start stays 0, state IDLE; no done ever asserted.
- Pause/resume: preset 00:01, start_p (start=1); pause_p at cycle 10 → pause=1; hold 20 cycles with cnt_zero=0; start_p → pause=0. cnt_zero driven high 50 cycles after resume → DONE next edge.
- Done timeout: DONE_CYCLES=10, force cnt_zero=1 in RUN → done=1 for exactly 10 cycles, then IDLE with start=0. Repeat with start_p at the 3rd DONE cycle → IDLE on the next edge.
- Simultaneous pulses: in RUN, set_p and pause_p in the same cycle → IDLE (not PAUSE). In IDLE, set_p and start_p together → SET.

Source files
------------

// File: rtl/timer_ctrl.sv
// rtl/timer_ctrl.sv - button-pulse control FSM and BCD preset store for the countdown timer chain
module timer_ctrl #(
  parameter int DONE_CYCLES = 10
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       set_p,
  input  logic       sel_p,
  input  logic       inc_p,
  input  logic       start_p,
  input  logic       pause_p,
  input  logic       cnt_zero,
  output logic       start,
  output logic       pause,
  output logic       setting,
  output logic [3:0] set_min_one,
  output logic [3:0] set_min_ten,
  output logic [3:0] set_hr_one,
  output logic [3:0] set_hr_ten,
  output logic [1:0] sel_digit,
  output logic       done
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_SET   = 3'd1,
    S_RUN   = 3'd2,
    S_PAUSE = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  localparam logic [7:0] DONE_LAST = 8'(DONE_CYCLES - 1);

  state_t     state_q, state_d;
  logic [7:0] done_cnt_q, done_cnt_d;
  logic       armed_q, armed_d;
  logic [3:0] min_one_q, min_one_d;
  logic [3:0] min_ten_q, min_ten_d;
  logic [3:0] hr_one_q, hr_one_d;
  logic [3:0] hr_ten_q, hr_ten_d;
  logic [1:0] sel_q, sel_d;
  logic       start_q, start_d;
  logic       pause_q, pause_d;
  logic       setting_q, setting_d;
  logic       done_q, done_d;
  logic       presets_nz;

  assign presets_nz = (min_one_q != 4'd0) || (min_ten_q != 4'd0) ||
                      (hr_one_q != 4'd0) || (hr_ten_q != 4'd0);

  // Next state, done timer and run-armed flag; pulse priority is set_p > start_p > pause_p.
  always_comb begin
    state_d    = state_q;
    done_cnt_d = 8'd0;
    case (state_q)
      S_IDLE: begin
        if (set_p)                        state_d = S_SET;
        else if (start_p && presets_nz)   state_d = S_RUN;
      end
      S_SET: begin
        if (set_p)                        state_d = S_IDLE;
      end
      S_RUN: begin
        if (set_p)                        state_d = S_IDLE;
        else if (pause_p)                 state_d = S_PAUSE;
        else if (armed_q && cnt_zero)     state_d = S_DONE;
      end
      S_PAUSE: begin
        if (set_p)                        state_d = S_IDLE;
        else if (start_p || pause_p)      state_d = S_RUN;
      end
      S_DONE: begin
        if (set_p || start_p)             state_d = S_IDLE;
        else if (done_cnt_q >= DONE_LAST) state_d = S_IDLE;
        else                              done_cnt_d = done_cnt_q + 8'd1;
      end
      default:                            state_d = S_IDLE;
    endcase
    // cnt_zero is only trusted once the counters have had a cycle in RUN.
    armed_d = (state_q == S_RUN) && (state_d == S_RUN);
  end

  // Preset digit editing, active only while sitting in SET.
  always_comb begin
    min_one_d = min_one_q;
    min_ten_d = min_ten_q;
    hr_one_d  = hr_one_q;
    hr_ten_d  = hr_ten_q;
    sel_d     = sel_q;
    if (state_q == S_IDLE && set_p) begin
      sel_d = 2'd0;
    end else if (state_q == S_SET) begin
      if (inc_p) begin
        case (sel_q)
          2'd0: min_one_d = (min_one_q >= 4'd9) ? 4'd0 : min_one_q + 4'd1;
          2'd1: min_ten_d = (min_ten_q >= 4'd5) ? 4'd0 : min_ten_q + 4'd1;
          2'd2: begin
            if (hr_ten_q == 4'd2) hr_one_d = (hr_one_q >= 4'd3) ? 4'd0 : hr_one_q + 4'd1;
            else                  hr_one_d = (hr_one_q >= 4'd9) ? 4'd0 : hr_one_q + 4'd1;
          end
          default: begin
            hr_ten_d = (hr_ten_q >= 4'd2) ? 4'd0 : hr_ten_q + 4'd1;
            // Entering the 20s: keep the hour at or below 23.
            if (hr_ten_q == 4'd1 && hr_one_q > 4'd3) hr_one_d = 4'd3;
          end
        endcase
      end
      if (sel_p) sel_d = sel_q + 2'd1;
    end
  end

  // Level outputs decoded from the next state so they switch on the transition edge.
  always_comb begin
    start_d   = 1'b0;
    pause_d   = 1'b0;
    setting_d = 1'b0;
    done_d    = 1'b0;
    case (state_d)
      S_SET:   setting_d = 1'b1;
      S_RUN:   start_d   = 1'b1;
      S_PAUSE: begin
        start_d = 1'b1;
        pause_d = 1'b1;
      end
      S_DONE: begin
        start_d = 1'b1;
        pause_d = 1'b1;
        done_d  = 1'b1;
      end
      default: ;
    endcase
  end

  // State, presets and registered outputs; reset is asynchronous and asserted high.
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      state_q    <= S_IDLE;
      done_cnt_q <= 8'd0;
      armed_q    <= 1'b0;
      min_one_q  <= 4'd0;
      min_ten_q  <= 4'd0;
      hr_one_q   <= 4'd0;
      hr_ten_q   <= 4'd0;
      sel_q      <= 2'd0;
      start_q    <= 1'b0;
      pause_q    <= 1'b0;
      setting_q  <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      done_cnt_q <= done_cnt_d;
      armed_q    <= armed_d;
      min_one_q  <= min_one_d;
      min_ten_q  <= min_ten_d;
      hr_one_q   <= hr_one_d;
      hr_ten_q   <= hr_ten_d;
      sel_q      <= sel_d;
      start_q    <= start_d;
      pause_q    <= pause_d;
      setting_q  <= setting_d;
      done_q     <= done_d;
    end
  end

  assign start       = start_q;
  assign pause       = pause_q;
  assign setting     = setting_q;
  assign done        = done_q;
  assign set_min_one = min_one_q;
  assign set_min_ten = min_ten_q;
  assign set_hr_one  = hr_one_q;
  assign set_hr_ten  = hr_ten_q;
  assign sel_digit   = sel_q;

endmodule

// File: tb/tb_timer_ctrl.sv
// tb/tb_timer_ctrl.sv - scoreboard bench for timer_ctrl
module tb_timer_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       set_p = 1'b0, sel_p = 1'b0, inc_p = 1'b0, start_p = 1'b0, pause_p = 1'b0;
  logic       cnt_zero = 1'b0;
  logic       start, pause, setting, done;
  logic [3:0] set_min_one, set_min_ten, set_hr_one, set_hr_ten;
  logic [1:0] sel_digit;

  int checks = 0;
  int failures = 0;

  typedef struct {
    string       name;
    logic [21:0] v;
  } exp_t;

  exp_t sb_q[$];

  timer_ctrl #(.DONE_CYCLES(10)) dut (
    .clk(clk), .rst_n(rst_n),
    .set_p(set_p), .sel_p(sel_p), .inc_p(inc_p), .start_p(start_p), .pause_p(pause_p),
    .cnt_zero(cnt_zero),
    .start(start), .pause(pause), .setting(setting),
    .set_min_one(set_min_one), .set_min_ten(set_min_ten),
    .set_hr_one(set_hr_one), .set_hr_ten(set_hr_ten),
    .sel_digit(sel_digit), .done(done)
  );

  always #5 clk = ~clk;

  // Monitor: drain the scoreboard mid-cycle, when outputs are stable.
  always @(negedge clk) begin
    while (sb_q.size() > 0) begin
      exp_t e;
      logic [21:0] act;
      e   = sb_q.pop_front();
      act = {start, pause, setting, done, sel_digit, set_hr_ten, set_hr_one, set_min_ten, set_min_one};
      checks++;
      if (act !== e.v) begin
        failures++;
        $display("FAIL %s: got st/pa/se/dn=%b sel=%0d hh:mm=%h%h:%h%h, want st/pa/se/dn=%b sel=%0d hh:mm=%h%h:%h%h",
                 e.name, act[21:18], act[17:16], act[15:12], act[11:8], act[7:4], act[3:0],
                 e.v[21:18], e.v[17:16], e.v[15:12], e.v[11:8], e.v[7:4], e.v[3:0]);
      end
    end
  end

  task automatic expect_out(input string name, input logic st, input logic pa, input logic se,
                            input logic dn, input logic [1:0] sel, input logic [3:0] ht,
                            input logic [3:0] ho, input logic [3:0] mt, input logic [3:0] mo);
    exp_t e;
    e.name = name;
    e.v    = {st, pa, se, dn, sel, ht, ho, mt, mo};
    sb_q.push_back(e);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    set_p = 1'b0; sel_p = 1'b0; inc_p = 1'b0; start_p = 1'b0; pause_p = 1'b0;
  endtask

  task automatic pulse(input logic s, input logic sl, input logic i, input logic st, input logic p);
    set_p = s; sel_p = sl; inc_p = i; start_p = st; pause_p = p;
    tick();
  endtask

  task automatic ticks(input int n);
    for (int k = 0; k < n; k++) tick();
  endtask

  initial begin
    // Reset held, then released
    ticks(2);
    expect_out("reset_state", 0, 0, 0, 0, 0, 0, 0, 0, 0);
    rst_n = 1'b0;
    tick();

    // Zero preset guard
    pulse(0, 0, 0, 1, 0);
    expect_out("zero_guard", 0, 0, 0, 0, 0, 0, 0, 0, 0);
    ticks(5);
    expect_out("zero_guard_hold", 0, 0, 0, 0, 0, 0, 0, 0, 0);

    // Editing and wrap
    pulse(1, 0, 0, 0, 0);
    expect_out("set_entry", 0, 0, 1, 0, 0, 0, 0, 0, 0);
    for (int k = 0; k < 9; k++) pulse(0, 0, 1, 0, 0);
    expect_out("min_one_9", 0, 0, 1, 0, 0, 0, 0, 0, 9);
    pulse(0, 0, 1, 0, 0);
    expect_out("min_one_wrap", 0, 0, 1, 0, 0, 0, 0, 0, 0);
    pulse(0, 0, 1, 0, 0);
    pulse(0, 1, 0, 0, 0);
    expect_out("sel_min_ten", 0, 0, 1, 0, 1, 0, 0, 0, 1);
    for (int k = 0; k < 5; k++) pulse(0, 0, 1, 0, 0);
    expect_out("min_ten_5", 0, 0, 1, 0, 1, 0, 0, 5, 1);
    pulse(0, 0, 1, 0, 0);
    expect_out("min_ten_wrap", 0, 0, 1, 0, 1, 0, 0, 0, 1);
    pulse(0, 1, 0, 0, 0);
    for (int k = 0; k < 7; k++) pulse(0, 0, 1, 0, 0);
    expect_out("hr_one_7", 0, 0, 1, 0, 2, 0, 7, 0, 1);
    pulse(0, 1, 0, 0, 0);
    pulse(0, 0, 1, 0, 0);
    expect_out("hr_ten_1", 0, 0, 1, 0, 3, 1, 7, 0, 1);
    pulse(0, 0, 1, 0, 0);
    expect_out("hr_clamp", 0, 0, 1, 0, 3, 2, 3, 0, 1);
    pulse(0, 1, 1, 0, 0);
    expect_out("sel_inc_same", 0, 0, 1, 0, 0, 0, 3, 0, 1);
    pulse(0, 0, 0, 1, 1);
    expect_out("set_ignores_run", 0, 0, 1, 0, 0, 0, 3, 0, 1);
    pulse(1, 0, 0, 0, 0);
    expect_out("set_exit", 0, 0, 0, 0, 0, 0, 3, 0, 1);
    pulse(0, 1, 1, 0, 0);
    expect_out("idle_edit_ignored", 0, 0, 0, 0, 0, 0, 3, 0, 1);

    // Pause/resume and completion (presets now 03:01)
    pulse(0, 0, 0, 1, 0);
    expect_out("run", 1, 0, 0, 0, 0, 0, 3, 0, 1);
    ticks(9);
    pulse(0, 0, 0, 0, 1);
    expect_out("pause", 1, 1, 0, 0, 0, 0, 3, 0, 1);
    cnt_zero = 1'b1;
    ticks(5);
    cnt_zero = 1'b0;
    ticks(15);
    expect_out("pause_ignores_zero", 1, 1, 0, 0, 0, 0, 3, 0, 1);
    pulse(0, 0, 0, 1, 0);
    expect_out("resume", 1, 0, 0, 0, 0, 0, 3, 0, 1);
    ticks(50);
    cnt_zero = 1'b1;
    tick();
    cnt_zero = 1'b0;
    expect_out("done_entry", 1, 1, 0, 1, 0, 0, 3, 0, 1);
    ticks(9);
    expect_out("done_last", 1, 1, 0, 1, 0, 0, 3, 0, 1);
    tick();
    expect_out("done_timeout", 0, 0, 0, 0, 0, 0, 3, 0, 1);

    // Early exit from DONE in its 3rd cycle
    pulse(0, 0, 0, 1, 0);
    ticks(2);
    cnt_zero = 1'b1;
    tick();
    cnt_zero = 1'b0;
    ticks(2);
    expect_out("done_3rd", 1, 1, 0, 1, 0, 0, 3, 0, 1);
    pulse(0, 0, 0, 1, 0);
    expect_out("done_early_exit", 0, 0, 0, 0, 0, 0, 3, 0, 1);

    // Simultaneous pulses
    pulse(0, 0, 0, 1, 0);
    expect_out("run_again", 1, 0, 0, 0, 0, 0, 3, 0, 1);
    pulse(1, 0, 0, 0, 1);
    expect_out("set_over_pause", 0, 0, 0, 0, 0, 0, 3, 0, 1);
    pulse(1, 0, 0, 1, 0);
    expect_out("set_over_start", 0, 0, 1, 0, 0, 0, 3, 0, 1);
    pulse(1, 0, 0, 0, 0);

    // Asynchronous reset mid-RUN
    pulse(0, 0, 0, 1, 0);
    ticks(5);
    expect_out("run_before_reset", 1, 0, 0, 0, 0, 0, 3, 0, 1);
    @(negedge clk);
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    #1;
    expect_out("reset_mid_run", 0, 0, 0, 0, 0, 0, 0, 0, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    ticks(2);
    expect_out("post_reset", 0, 0, 0, 0, 0, 0, 0, 0, 0);

    @(negedge clk);
    #1;
    checks++;
    if (sb_q.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain: got %0d pending, want 0", sb_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
